// File: rtl/mod_det_5x5.sv
// Sequential 5x5 signed determinant by Laplace expansion along row 0, one 4x4 minor per clock.
// Latency 5 clocks from accepted start to done; start is ignored while a computation runs.
module mod_det_5x5 (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [7:0]  a,
    input  logic signed [7:0]  b,
    input  logic signed [7:0]  c,
    input  logic signed [7:0]  d,
    input  logic signed [7:0]  e,
    input  logic signed [7:0]  f,
    input  logic signed [7:0]  g,
    input  logic signed [7:0]  h,
    input  logic signed [7:0]  i,
    input  logic signed [7:0]  j,
    input  logic signed [7:0]  k,
    input  logic signed [7:0]  l,
    input  logic signed [7:0]  m,
    input  logic signed [7:0]  n,
    input  logic signed [7:0]  o,
    input  logic signed [7:0]  p,
    input  logic signed [7:0]  q,
    input  logic signed [7:0]  r,
    input  logic signed [7:0]  s,
    input  logic signed [7:0]  t,
    input  logic signed [7:0]  u,
    input  logic signed [7:0]  v,
    input  logic signed [7:0]  w,
    input  logic signed [7:0]  x,
    input  logic signed [7:0]  y,
    output logic signed [15:0] resultado,
    output logic               done,
    output logic signed [15:0] sub1,
    output logic signed [15:0] sub2,
    output logic signed [15:0] sub3,
    output logic signed [15:0] sub4,
    output logic signed [15:0] sub5
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state;
    logic signed [7:0]   in_mat  [5][5];
    logic signed [7:0]   mat     [5][5];
    logic signed [15:0]  sub_r   [5];
    logic [2:0]          idx;
    logic signed [41:0]  acc;

    logic [2:0]          col_src [4];
    logic signed [41:0]  sel     [4][4];
    logic signed [41:0]  minor;
    logic signed [41:0]  pivot;
    logic signed [41:0]  term;
    logic signed [41:0]  acc_next;

    assign in_mat[0] = '{a, b, c, d, e};
    assign in_mat[1] = '{f, g, h, i, j};
    assign in_mat[2] = '{k, l, m, n, o};
    assign in_mat[3] = '{p, q, r, s, t};
    assign in_mat[4] = '{u, v, w, x, y};

    assign sub1 = sub_r[0];
    assign sub2 = sub_r[1];
    assign sub3 = sub_r[2];
    assign sub4 = sub_r[3];
    assign sub5 = sub_r[4];

    function automatic logic signed [41:0] ext(input logic signed [7:0] val);
        return {{34{val[7]}}, val};
    endfunction

    function automatic logic signed [41:0] det3(
        input logic signed [41:0] m00, input logic signed [41:0] m01, input logic signed [41:0] m02,
        input logic signed [41:0] m10, input logic signed [41:0] m11, input logic signed [41:0] m12,
        input logic signed [41:0] m20, input logic signed [41:0] m21, input logic signed [41:0] m22
    );
        return m00 * (m11 * m22 - m12 * m21)
             - m01 * (m10 * m22 - m12 * m20)
             + m02 * (m10 * m21 - m11 * m20);
    endfunction

    // Column map that skips the column currently being expanded in row 0.
    always_comb begin
        for (int cc = 0; cc < 4; cc++) begin
            col_src[cc] = (3'(cc) < idx) ? 3'(cc) : 3'(cc + 1);
        end
    end

    always_comb begin
        for (int rr = 0; rr < 4; rr++) begin
            for (int cc = 0; cc < 4; cc++) begin
                sel[rr][cc] = ext(mat[rr + 1][col_src[cc]]);
            end
        end
    end

    always_comb begin
        minor = sel[0][0] * det3(sel[1][1], sel[1][2], sel[1][3],
                                 sel[2][1], sel[2][2], sel[2][3],
                                 sel[3][1], sel[3][2], sel[3][3])
              - sel[0][1] * det3(sel[1][0], sel[1][2], sel[1][3],
                                 sel[2][0], sel[2][2], sel[2][3],
                                 sel[3][0], sel[3][2], sel[3][3])
              + sel[0][2] * det3(sel[1][0], sel[1][1], sel[1][3],
                                 sel[2][0], sel[2][1], sel[2][3],
                                 sel[3][0], sel[3][1], sel[3][3])
              - sel[0][3] * det3(sel[1][0], sel[1][1], sel[1][2],
                                 sel[2][0], sel[2][1], sel[2][2],
                                 sel[3][0], sel[3][1], sel[3][2]);
        pivot    = ext(mat[0][idx]);
        term     = pivot * minor;
        acc_next = idx[0] ? (acc - term) : (acc + term);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 3'd0;
            acc       <= '0;
            resultado <= '0;
            done      <= 1'b0;
            for (int ii = 0; ii < 5; ii++) begin
                sub_r[ii] <= '0;
                for (int jj = 0; jj < 5; jj++) begin
                    mat[ii][jj] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        for (int ii = 0; ii < 5; ii++) begin
                            for (int jj = 0; jj < 5; jj++) begin
                                mat[ii][jj] <= in_mat[ii][jj];
                            end
                        end
                        idx   <= 3'd0;
                        acc   <= '0;
                        done  <= 1'b0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    sub_r[idx] <= minor[15:0];
                    acc        <= acc_next;
                    if (idx == 3'd4) begin
                        resultado <= acc_next[15:0];
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_det_5x5.sv
// Scoreboard bench for mod_det_5x5: expected minors/determinant come from a Leibniz-formula model.
module tb_mod_det_5x5;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [7:0]  tm [5][5];
    logic signed [15:0] resultado, sub1, sub2, sub3, sub4, sub5;
    logic               done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0][15:0] sub;
        logic [15:0]      res;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mod_det_5x5 dut (
        .clk(clk), .rst(rst), .start(start),
        .a(tm[0][0]), .b(tm[0][1]), .c(tm[0][2]), .d(tm[0][3]), .e(tm[0][4]),
        .f(tm[1][0]), .g(tm[1][1]), .h(tm[1][2]), .i(tm[1][3]), .j(tm[1][4]),
        .k(tm[2][0]), .l(tm[2][1]), .m(tm[2][2]), .n(tm[2][3]), .o(tm[2][4]),
        .p(tm[3][0]), .q(tm[3][1]), .r(tm[3][2]), .s(tm[3][3]), .t(tm[3][4]),
        .u(tm[4][0]), .v(tm[4][1]), .w(tm[4][2]), .x(tm[4][3]), .y(tm[4][4]),
        .resultado(resultado), .done(done),
        .sub1(sub1), .sub2(sub2), .sub3(sub3), .sub4(sub4), .sub5(sub5)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint det4(input longint mx[4][4]);
        longint sum = 0;
        longint prod;
        int inv;
        for (int p0 = 0; p0 < 4; p0++)
            for (int p1 = 0; p1 < 4; p1++)
                for (int p2 = 0; p2 < 4; p2++)
                    for (int p3 = 0; p3 < 4; p3++) begin
                        if (p0 != p1 && p0 != p2 && p0 != p3 && p1 != p2 && p1 != p3 && p2 != p3) begin
                            inv = 0;
                            if (p0 > p1) inv++;
                            if (p0 > p2) inv++;
                            if (p0 > p3) inv++;
                            if (p1 > p2) inv++;
                            if (p1 > p3) inv++;
                            if (p2 > p3) inv++;
                            prod = mx[0][p0] * mx[1][p1] * mx[2][p2] * mx[3][p3];
                            sum = (inv % 2 == 1) ? sum - prod : sum + prod;
                        end
                    end
        return sum;
    endfunction

    function automatic exp_t model();
        exp_t   res_e;
        longint mx[4][4];
        longint mk;
        longint det = 0;
        for (int kk = 0; kk < 5; kk++) begin
            for (int rr = 0; rr < 4; rr++)
                for (int cc = 0; cc < 4; cc++)
                    mx[rr][cc] = longint'(tm[rr + 1][(cc < kk) ? cc : cc + 1]);
            mk = det4(mx);
            res_e.sub[kk] = mk[15:0];
            det = (kk % 2 == 1) ? det - longint'(tm[0][kk]) * mk : det + longint'(tm[0][kk]) * mk;
        end
        res_e.res = det[15:0];
        return res_e;
    endfunction

    task automatic set_mat(input int vals[25]);
        for (int ii = 0; ii < 25; ii++) begin
            int tmp;
            tmp = vals[ii];
            tm[ii / 5][ii % 5] = tmp[7:0];
        end
    endtask

    task automatic set_diag(input int dv);
        for (int ii = 0; ii < 5; ii++)
            for (int jj = 0; jj < 5; jj++)
                tm[ii][jj] = (ii == jj) ? 8'(dv) : 8'sd0;
    endtask

    task automatic set_random();
        for (int ii = 0; ii < 5; ii++)
            for (int jj = 0; jj < 5; jj++)
                tm[ii][jj] = 8'($urandom_range(0, 255));
    endtask

    task automatic launch(input bit push);
        @(negedge clk);
        start = 1'b1;
        if (push) sb.push_back(model());
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done_drop_on_start", done, 0);
    endtask

    task automatic wait_done(input string tag, input int elapsed);
        int   lat = 0;
        exp_t ex;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = elapsed + cyc;
                break;
            end
        end
        check({tag, "_latency"}, lat, 5);
        check({tag, "_sb_depth"}, sb.size(), 1);
        if (sb.size() > 0) begin
            ex = sb.pop_front();
            check({tag, "_sub1"}, sub1, $signed(ex.sub[0]));
            check({tag, "_sub2"}, sub2, $signed(ex.sub[1]));
            check({tag, "_sub3"}, sub3, $signed(ex.sub[2]));
            check({tag, "_sub4"}, sub4, $signed(ex.sub[3]));
            check({tag, "_sub5"}, sub5, $signed(ex.sub[4]));
            check({tag, "_det"}, resultado, $signed(ex.res));
        end
    endtask

    initial begin
        int spec_m[25];
        rst   = 1'b1;
        start = 1'b0;
        set_diag(0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", done, 0);
        check("rst_det", resultado, 0);
        check("rst_sub1", sub1, 0);
        check("rst_sub3", sub3, 0);
        check("rst_sub5", sub5, 0);
        @(negedge clk);
        rst = 1'b0;

        spec_m = '{1, 2, 2, 2, 1,  2, 1, 2, 2, 1,  1, 3, 3, 1, 2,  2, 2, 1, 2, 1,  2, 1, 1, 1, 2};
        set_mat(spec_m);
        launch(1'b1);
        wait_done("ref", 0);
        check("ref_sub1_k", sub1, -12);
        check("ref_sub2_k", sub2, 3);
        check("ref_sub3_k", sub3, -3);
        check("ref_sub4_k", sub4, -12);
        check("ref_sub5_k", sub5, 9);
        check("ref_det_k", resultado, 9);
        set_random();
        repeat (3) @(posedge clk);
        #1;
        check("hold_done", done, 1);
        check("hold_det", resultado, 9);

        set_diag(1);
        launch(1'b1);
        wait_done("ident", 0);
        check("ident_sub1_k", sub1, 1);
        check("ident_sub2_k", sub2, 0);
        check("ident_det_k", resultado, 1);

        set_random();
        tm[3] = tm[1];
        launch(1'b1);
        wait_done("singular", 0);
        check("singular_det_k", resultado, 0);

        set_diag(100);
        launch(1'b1);
        wait_done("ovf", 0);
        check("ovf_sub1_k", sub1, -7936);
        check("ovf_det_k", resultado, -7168);

        // Perturb inputs and pulse start over two CALC edges.
        set_random();
        launch(1'b1);
        @(negedge clk);
        set_random();
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_done("robust", 2);

        for (int rep = 0; rep < 4; rep++) begin
            set_random();
            launch(1'b1);
            wait_done("rand", 0);
        end

        set_random();
        launch(1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_done", done, 0);
        check("midrst_det", resultado, 0);
        check("midrst_sub1", sub1, 0);
        check("midrst_sub2", sub2, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_stay_idle", done, 0);
        check("midrst_det_stay", resultado, 0);

        set_diag(1);
        launch(1'b1);
        wait_done("b2b_first", 0);
        set_diag(-1);
        launch(1'b1);
        wait_done("b2b_second", 0);
        check("b2b_det_k", resultado, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
